bridge_timer: RTL and testbench
===============================

# bridge_timer

Memory-mapped countdown timer that sits on the far side of the CPU's processor bridge and answers the CPU's `PrAddr`/`PrWD`/`PrWe`/`PrRD` accesses. Its interrupt output drives one bit of the CPU's `HWInt[7:2]`. It has three word registers (CTRL, PRESET, COUNT) and supports two modes: one-shot, and auto-reload (periodic).

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset); clears all state immediately.
- `Addr`  in  2  word select, taken from `PrAddr[3:2]`: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unused.
- `We`  in  1  write strobe; the bridge qualifies it with address decode.
- `DIn`  in  32  write data, taken from `PrWD`.
- `DOut`  out  32  read data, returned on `PrRD`; combinational.
- `IRQ`  out  1  interrupt request, routed to `HWInt`.

## Operation
- CTRL register layout:
  - [0] En: enable.
  - [2:1] Mode: 00 = one-shot; 01 = auto-reload; 10 and 11 behave as 00.
  - [3] IM: interrupt mask, 1 = interrupt allowed.
  - [31:4] read as 0.
- Writes, performed when `We`=1 at the clock edge:
  - Addr 0 loads CTRL[3:0] from DIn[3:0] and clears `pend`.
  - Addr 1 loads PRESET from the full 32 bits of DIn.
  - Addr 2 and Addr 3 writes are ignored.
- Reads: `DOut` = {28'b0, CTRL[3:0]} / PRESET / COUNT / 0, selected by Addr. A read has no side effects.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if En=1, go to LOAD. Otherwise stay; COUNT holds.
  - LOAD: COUNT ← PRESET; go to CNT.
  - CNT: if En=0, go to IDLE with COUNT frozen. Else if COUNT > 1, COUNT ← COUNT−1. Else (COUNT ≤ 1), COUNT ← 0, `pend` ← 1, go to INT.
  - INT, Mode 01: `pend` ← 0; go to LOAD.
  - INT, other modes: En ← 0; go to IDLE. `pend` is held until the next CTRL write.
- `IRQ` = `pend` & IM.
- COUNT arithmetic is unsigned 32-bit. It never wraps below 0. PRESET = 0 behaves like PRESET = 1 (INT is reached on the first CNT cycle).
- A PRESET write during CNT does not change COUNT. The new value takes effect at the next LOAD.
- A CTRL write in the same cycle as the hardware En-clear in INT: the software value wins for both En and `pend`. The FSM still goes to IDLE and, if En=1, proceeds to LOAD on the following edge.
- Writes have no wait states: the bridge never stalls this device.

## Timing
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, `pend` = 0, state = IDLE. Therefore `IRQ` = 0, and `DOut` = 0 for every Addr.
- Reset asserted mid-count: all registers clear asynchronously, `IRQ` drops without waiting for a clock edge, and no interrupt fires after reset deasserts.
- A register write is visible on `DOut` in the cycle after its edge.
- Latency from an enabling CTRL write at edge t0 with PRESET = N ≥ 1:
  - LOAD state during cycle t0+1.
  - COUNT = N after edge t0+2.
  - COUNT = 1 after edge t0+N+1.
  - INT entered and `IRQ` rises (if IM=1) after edge t0+N+2.
- Mode 01 period: `IRQ` is a 1-cycle pulse every N+2 cycles (1 cycle INT + 1 cycle LOAD + N cycles CNT).
- Mode 00: `IRQ` stays high from INT entry until the first CTRL write. It falls after that write's edge.
- IM changes mask `IRQ` combinationally on the next cycle; `pend` is unaffected by IM.

## Test plan
- One-shot: reset, write PRESET=5, then write CTRL=0x9 at edge t0. Required: COUNT reads 5,4,3,2,1 on successive cycles from t0+2. COUNT = 0 and `IRQ`=1 after edge t0+7. CTRL then reads 0x8. `IRQ` stays 1 for 20 idle cycles and drops after a write of CTRL=0x8.
- Auto-reload: PRESET=3, CTRL=0xB. Required: `IRQ` is a 1-cycle pulse every 5 cycles for at least 4 periods, and COUNT cycles through 3,2,1,0.
- Mask and disable: PRESET=4 with CTRL=0x1 (IM=0). Required: COUNT reaches 0 and `IRQ` stays 0. Separately, clear En mid-count at COUNT=2. Required: COUNT holds at 2 and no interrupt occurs.
- Edge values: PRESET=0 gives `IRQ` after edge t0+3. PRESET=0xFFFFFFFF decrements to 0xFFFFFFFE with no wrap. A PRESET write of 9 during CNT leaves the current countdown intact, and 9 is used after the next reload.
- Bus: write Addr 2 (COUNT) and Addr 3. Required: no register changes and `DOut` at Addr 3 = 0. Write CTRL=0xFFFFFFFF. Required: CTRL reads 0xF (Mode 11 behaves as one-shot).
- Reset: assert `reset`=0 mid-count and mid-`IRQ`. Required: `IRQ` and every `DOut` value are 0 before the next edge, and after reset deasserts the FSM is in IDLE with no spurious interrupt.

Source files
------------

// File: rtl/bridge_timer.sv
// Memory-mapped countdown timer behind the processor bridge: CTRL/PRESET/COUNT
// registers, one-shot or auto-reload countdown, maskable level interrupt.
module bridge_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        pend;

  logic        en;
  logic [1:0]  mode;
  logic        im;

  assign en   = ctrl[0];
  assign mode = ctrl[2:1];
  assign im   = ctrl[3];

  // Decrement that floors at zero so COUNT can never wrap.
  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v > 32'd1) ? (v - 32'd1) : 32'd0;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ctrl   <= 4'd0;
      preset <= 32'd0;
      count  <= 32'd0;
      pend   <= 1'b0;
    end else begin
      if (We && (Addr == 2'd1))
        preset <= DIn;

      case (state)
        IDLE: begin
          if (en)
            state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else begin
            count <= sat_dec(count);
            if (count <= 32'd1) begin
              pend  <= 1'b1;
              state <= INT;
            end
          end
        end
        INT: begin
          if (mode == 2'b01) begin
            pend  <= 1'b0;
            state <= LOAD;
          end else begin
            ctrl[0] <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Placed last so a software CTRL write overrides the hardware En/pend updates.
      if (We && (Addr == 2'd0)) begin
        ctrl <= DIn[3:0];
        pend <= 1'b0;
      end
    end
  end

  always_comb begin
    DOut = 32'd0;
    case (Addr)
      2'd0:    DOut = {28'd0, ctrl};
      2'd1:    DOut = preset;
      2'd2:    DOut = count;
      default: DOut = 32'd0;
    endcase
  end

  assign IRQ = pend & im;

endmodule

// File: tb/tb_bridge_timer.sv
// Directed bench for bridge_timer: register table plus hand-timed countdown sequences.
`timescale 1ns/1ps
module tb_bridge_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  int checks   = 0;
  int failures = 0;

  bridge_timer dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .We   (We),
    .DIn  (DIn),
    .DOut (DOut),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [1:0]  raddr;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(nm, DOut, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a;
    DIn  = d;
    We   = 1'b1;
    @(posedge clk);
    #1;
    We   = 1'b0;
    Addr = 2'd0;
    DIn  = 32'd0;
  endtask

  task automatic rst_pulse(input string nm);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk({nm, "_irq_async"}, IRQ, 0);
    for (int a = 0; a < 4; a++)
      chk_rd({nm, "_dout_async"}, a[1:0], 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    chk({nm, "_irq_after"}, IRQ, 0);
    chk_rd({nm, "_count_after"}, 2'd2, 32'd0);
    chk_rd({nm, "_ctrl_after"}, 2'd0, 32'd0);
  endtask

  initial begin
    logic        ok;
    logic        exp_irq;
    logic [31:0] exp_cnt;
    int          ph;

    reset = 1'b0;
    We    = 1'b0;
    Addr  = 2'd0;
    DIn   = 32'd0;

    tbl[0]  = '{1'b0, 2'd0, 32'h0,        2'd0, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 2'd0, 32'h0,        2'd1, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 2'd0, 32'h0,        2'd3, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 2'd1, 32'h12345678, 2'd1, 32'h12345678, 1'b0};
    tbl[5]  = '{1'b1, 2'd2, 32'h0000DEAD, 2'd2, 32'h0,        1'b0};
    tbl[6]  = '{1'b1, 2'd3, 32'h0000BEEF, 2'd3, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, 2'd0, 32'h0,        2'd1, 32'h12345678, 1'b0};
    tbl[8]  = '{1'b1, 2'd0, 32'hFFFFFFFF, 2'd0, 32'hF,        1'b0};
    tbl[9]  = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h12345678, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h12345677, 1'b0};
    tbl[12] = '{1'b0, 2'd0, 32'h0,        2'd0, 32'hF,        1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Register table: one clock edge per row.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      We   = tbl[i].we;
      Addr = tbl[i].addr;
      DIn  = tbl[i].din;
      @(posedge clk);
      #1;
      We   = 1'b0;
      DIn  = 32'd0;
      chk_rd($sformatf("tbl%0d_dout", i), tbl[i].raddr, tbl[i].exp_dout);
      chk($sformatf("tbl%0d_irq", i), IRQ, tbl[i].exp_irq);
    end

    // Reset while counting from 0x12345678.
    rst_pulse("rst_midcount");

    // One-shot, PRESET=5.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step();
    chk_rd("os_load_count", 2'd2, 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk_rd($sformatf("os_count_%0d", k), 2'd2, 32'd5 - k);
      chk($sformatf("os_irq_lo_%0d", k), IRQ, 0);
      step();
    end
    chk_rd("os_count_zero", 2'd2, 32'd0);
    chk("os_irq_hi", IRQ, 1);
    step();
    chk_rd("os_ctrl_en_clr", 2'd0, 32'h8);
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (IRQ !== 1'b1) ok = 1'b0;
    end
    chk("os_irq_hold20", ok, 1);
    wr(2'd0, 32'h8);
    chk("os_irq_cleared", IRQ, 0);
    chk_rd("os_ctrl_after_clr", 2'd0, 32'h8);

    // Auto-reload, PRESET=3: 5-cycle period.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 24; k++) begin
      step();
      exp_irq = (k >= 5) && (((k - 5) % 5) == 0);
      if (k < 2) begin
        exp_cnt = 32'd0;
      end else begin
        ph = (k - 2) % 5;
        exp_cnt = (ph < 3) ? (32'd3 - ph) : 32'd0;
      end
      chk($sformatf("ar_irq_t%0d", k), IRQ, exp_irq);
      chk_rd($sformatf("ar_count_t%0d", k), 2'd2, exp_cnt);
    end
    wr(2'd0, 32'h0);
    rst_pulse("rst_after_ar");

    // Masked one-shot, PRESET=4, IM=0.
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("mask_irq_t%0d", k), IRQ, 0);
    end
    chk_rd("mask_count_zero", 2'd2, 32'd0);
    step();
    chk_rd("mask_ctrl_en_clr", 2'd0, 32'h0);
    chk("mask_irq_idle", IRQ, 0);

    // Disable mid-count: write lands when COUNT reads 3, COUNT freezes at 2.
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h9);
    repeat (5) step();
    chk_rd("dis_count_pre", 2'd2, 32'd3);
    wr(2'd0, 32'h8);
    chk_rd("dis_count_2", 2'd2, 32'd2);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_rd($sformatf("dis_hold_%0d", k), 2'd2, 32'd2);
      chk($sformatf("dis_irq_%0d", k), IRQ, 0);
    end

    // PRESET=0 reaches INT on the first CNT cycle.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step();
    chk("p0_irq_t1", IRQ, 0);
    step();
    chk_rd("p0_count_t2", 2'd2, 32'd0);
    chk("p0_irq_t2", IRQ, 0);
    step();
    chk("p0_irq_t3", IRQ, 1);
    wr(2'd0, 32'h8);
    chk("p0_irq_clr", IRQ, 0);

    // Maximum PRESET decrements without wrapping.
    wr(2'd1, 32'hFFFFFFFF);
    wr(2'd0, 32'h9);
    repeat (2) step();
    chk_rd("max_count_load", 2'd2, 32'hFFFFFFFF);
    step();
    chk_rd("max_count_dec", 2'd2, 32'hFFFFFFFE);
    wr(2'd0, 32'h8);
    step();

    // PRESET rewrite during CNT only takes effect at the next reload.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    repeat (2) step();
    chk_rd("pw_count_3", 2'd2, 32'd3);
    wr(2'd1, 32'd9);
    chk_rd("pw_count_2", 2'd2, 32'd2);
    step();
    chk_rd("pw_count_1", 2'd2, 32'd1);
    step();
    chk_rd("pw_count_0", 2'd2, 32'd0);
    chk("pw_irq_hi", IRQ, 1);
    step();
    chk("pw_irq_pulse_end", IRQ, 0);
    step();
    chk_rd("pw_count_9", 2'd2, 32'd9);
    chk_rd("pw_preset_9", 2'd1, 32'd9);
    wr(2'd0, 32'h0);

    // Reset while IRQ is asserted.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    repeat (3) step();
    chk("rirq_irq_hi", IRQ, 1);
    rst_pulse("rst_mid_irq");
    repeat (4) step();
    chk("rirq_no_spurious", IRQ, 0);
    chk_rd("rirq_preset_clr", 2'd1, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
